// File: rtl/ifmap_spad_writer_pkg.sv
// Shared types and constants for the ifmap scratchpad writer and its pointer helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ifmap_spad_writer_pkg;

  // Write-side controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } wr_state_e;

  localparam int DEF_IFMAP_DATA_WIDTH = 8;
  localparam int DEF_SPAD_DEPTH       = 12;

  // Index of the last scratchpad entry; pointers wrap after this value
  function automatic int spad_last(input int depth);
    return depth - 1;
  endfunction

  localparam int DEF_SPAD_LAST = spad_last(DEF_SPAD_DEPTH);

endpackage

// File: rtl/ifmap_spad_writer_if.sv
// Bundle of stream, scratchpad-write, release and row-publish signals for the writer.
// Latency: n/a (wiring only).
// Backpressure: in_ready is driven by the writer (slave); all other flow is master-driven.
interface ifmap_spad_writer_if #(
  parameter int IFMAP_DATA_WIDTH = 8,
  parameter int SPAD_DEPTH       = 12,
  parameter int ADDR_W           = $clog2(SPAD_DEPTH)
);
  logic                        start;
  logic                        in_valid;
  logic [IFMAP_DATA_WIDTH-1:0] in_data;
  logic                        in_last;
  logic                        in_ready;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [IFMAP_DATA_WIDTH-1:0] wr_data;
  logic                        release_en;
  logic [ADDR_W:0]             release_cnt;
  logic                        row_valid;
  logic [ADDR_W-1:0]           row_base;
  logic [ADDR_W:0]             row_len;
  logic                        row_ack;
  logic [ADDR_W:0]             count;
  logic                        full;
  logic                        empty;
  logic                        err;

  modport master (
    output start, in_valid, in_data, in_last, release_en, release_cnt, row_ack,
    input  in_ready, wr_en, wr_addr, wr_data, row_valid, row_base, row_len,
           count, full, empty, err
  );

  modport slave (
    input  start, in_valid, in_data, in_last, release_en, release_cnt, row_ack,
    output in_ready, wr_en, wr_addr, wr_data, row_valid, row_base, row_len,
           count, full, empty, err
  );
endinterface

// File: rtl/ifmap_spad_writer_spad_wrap_ptr.sv
// Circular pointer over DEPTH entries (DEPTH need not be a power of two).
// Latency: advances one cycle after i_en.
// Backpressure: none; caller gates i_en.
module spad_wrap_ptr
  import ifmap_spad_writer_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_ptr
);
  localparam int           LAST_I = spad_last(DEPTH);
  localparam logic [W-1:0] LAST   = LAST_I[W-1:0];

  logic [W-1:0] r_ptr;

  // Step the pointer, wrapping explicitly at the last entry rather than by overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/ifmap_spad_writer.sv
// Captures ifmap rows from a valid/ready stream into a circular scratchpad and publishes row base/length.
// Latency: zero-latency write (wr_en in the accepting cycle); row_valid one cycle after the last beat.
// Backpressure: in_ready only in FILL while not full; drops the same cycle count reaches SPAD_DEPTH.
module ifmap_spad_writer
  import ifmap_spad_writer_pkg::*;
#(
  parameter int IFMAP_DATA_WIDTH = 8,
  parameter int SPAD_DEPTH       = 12,
  parameter int ADDR_W           = $clog2(SPAD_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  ifmap_spad_writer_if.slave    bus
);
  localparam logic [ADDR_W:0] DEPTH_C = SPAD_DEPTH[ADDR_W:0];

  wr_state_e         r_state;
  logic              r_row_valid;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W:0]   r_row_len;
  logic [ADDR_W:0]   r_beat_cnt;
  logic [ADDR_W:0]   r_count;
  logic              r_err;

  logic [ADDR_W-1:0] w_wr_ptr;
  logic              w_full;
  logic              w_empty;
  logic              w_in_ready;
  logic              w_accept;
  logic [ADDR_W:0]   w_beat_nxt;
  logic              w_row_overrun;
  logic [ADDR_W+1:0] w_cnt_sum;
  logic [ADDR_W+1:0] w_rel_amt;
  logic [ADDR_W+1:0] w_cnt_diff;
  logic              w_rel_over;

  assign w_full        = (r_count == DEPTH_C);
  assign w_empty       = (r_count == '0);
  // rst blocks acceptance so nothing is written in the reset cycle
  assign w_in_ready    = (r_state == ST_FILL) && !w_full && !rst;
  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_beat_nxt    = r_beat_cnt + 1'b1;
  assign w_row_overrun = w_accept && !bus.in_last && (w_beat_nxt == DEPTH_C);

  // One extra bit so release_cnt larger than the occupancy can be detected
  assign w_cnt_sum  = {1'b0, r_count} + {{(ADDR_W+1){1'b0}}, w_accept};
  assign w_rel_amt  = bus.release_en ? {1'b0, bus.release_cnt} : '0;
  assign w_rel_over = (w_rel_amt > w_cnt_sum);
  assign w_cnt_diff = w_cnt_sum - w_rel_amt;

  spad_wrap_ptr #(
    .DEPTH (SPAD_DEPTH),
    .W     (ADDR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_accept),
    .o_ptr (w_wr_ptr)
  );

  // Row capture FSM: arm on start, fill until last or overrun, hold until the reader acks
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row_valid <= 1'b0;
      r_row_base  <= '0;
      r_row_len   <= '0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_row_base <= w_wr_ptr;
            r_beat_cnt <= '0;
            r_state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            r_beat_cnt <= w_beat_nxt;
            if (bus.in_last) begin
              r_row_len   <= w_beat_nxt;
              r_row_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end else if (w_beat_nxt == DEPTH_C) begin
              r_row_len   <= DEPTH_C;
              r_row_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.row_ack) begin
            r_row_valid <= 1'b0;
            if (bus.start) begin
              r_row_base <= w_wr_ptr;
              r_beat_cnt <= '0;
              r_state    <= ST_FILL;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_row_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Occupancy: accept and release land in the same cycle; over-release clamps to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_rel_over) begin
      r_count <= '0;
    end else begin
      r_count <= w_cnt_diff[ADDR_W:0];
    end
  end

  // Sticky error: row overrun or release beyond occupancy; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_rel_over || w_row_overrun) begin
      r_err <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.wr_en     = w_accept;
  assign bus.wr_addr   = w_wr_ptr;
  assign bus.wr_data   = bus.in_data;
  assign bus.row_valid = r_row_valid;
  assign bus.row_base  = r_row_base;
  assign bus.row_len   = r_row_len;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_ifmap_spad_writer.sv
module tb_ifmap_spad_writer;
  localparam int DW    = 8;
  localparam int DEPTH = 12;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic rst;

  ifmap_spad_writer_if #(.IFMAP_DATA_WIDTH(DW), .SPAD_DEPTH(DEPTH), .ADDR_W(AW)) ifc ();

  ifmap_spad_writer #(.IFMAP_DATA_WIDTH(DW), .SPAD_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  int   m_ptr   = 0;
  int   m_count = 0;
  logic m_err   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every scratchpad write must match the oldest expected beat
  always @(negedge clk) begin
    if (ifc.wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected addr=%0d data=%0h with no beat expected", ifc.wr_addr, ifc.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (ifc.wr_addr !== e.addr || ifc.wr_data !== e.data) begin
          errors++;
          $display("FAIL wr_beat got addr=%0d data=%0h expected addr=%0d data=%0h",
                   ifc.wr_addr, ifc.wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.start = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_last = 1'b0;
    ifc.release_en = 1'b0; ifc.release_cnt = '0; ifc.row_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_ptr = 0; m_count = 0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_row();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic ack_row();
    ifc.row_ack = 1'b1;
    tick();
    ifc.row_ack = 1'b0;
  endtask

  task automatic release_pulse(input int n);
    ifc.release_en  = 1'b1;
    ifc.release_cnt = n[AW:0];
    tick();
    ifc.release_en = 1'b0;
    if (n > m_count) begin m_count = 0; m_err = 1'b1; end
    else m_count = m_count - n;
  endtask

  // Present one beat, wait (bounded) for acceptance, update the model
  task automatic send_beat(input logic [DW-1:0] d, input logic last, output int stalls);
    wr_t e;
    int  p;
    p = m_ptr;
    e.addr = p[AW-1:0];
    e.data = d;
    exp_q.push_back(e);
    ifc.in_valid = 1'b1; ifc.in_data = d; ifc.in_last = last;
    stalls = 0;
    @(negedge clk);
    while (ifc.in_ready !== 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (ifc.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL beat_timeout data=%0h in_ready=%b after %0d cycles", d, ifc.in_ready, stalls);
      void'(exp_q.pop_back());
      ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
      tick();
      return;
    end
    tick();
    m_ptr = (m_ptr == DEPTH - 1) ? 0 : m_ptr + 1;
    m_count++;
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.wr_en !== 1'b0 || ifc.row_valid !== 1'b0 ||
        ifc.count !== 5'd0 || ifc.empty !== 1'b1 || ifc.full !== 1'b0 || ifc.err !== 1'b0 ||
        ifc.row_base !== 4'd0 || ifc.row_len !== 5'd0) begin
      errors++;
      $display("FAIL reset_state rdy=%b wr=%b rv=%b cnt=%0d empty=%b full=%b err=%b base=%0d len=%0d required 0 0 0 0 1 0 0 0 0",
               ifc.in_ready, ifc.wr_en, ifc.row_valid, ifc.count, ifc.empty, ifc.full, ifc.err,
               ifc.row_base, ifc.row_len);
    end
    tick();
  endtask

  task automatic test_basic_row();
    int st, total;
    total = 0;
    start_row();
    for (int i = 1; i <= 5; i++) begin
      send_beat(i[DW-1:0], (i == 5), st);
      total += st;
    end
    @(negedge clk);
    checks++;
    if (total != 0) begin errors++; $display("FAIL basic_stalls got %0d required 0", total); end
    checks++;
    if (ifc.row_valid !== 1'b1 || ifc.row_base !== 4'd0 || ifc.row_len !== 5'd5 ||
        ifc.count !== 5'(m_count) || ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_row rv=%b base=%0d len=%0d cnt=%0d rdy=%b required 1 0 5 %0d 0",
               ifc.row_valid, ifc.row_base, ifc.row_len, ifc.count, ifc.in_ready, m_count);
    end
    tick();
    ack_row();
    @(negedge clk);
    checks++;
    if (ifc.row_valid !== 1'b0 || ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack rv=%b rdy=%b required 0 0", ifc.row_valid, ifc.in_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int st, base2;
    start_row();
    send_beat(8'h40, 1'b1, st);
    base2 = m_ptr;
    ifc.start = 1'b1; ifc.row_ack = 1'b1;
    tick();
    ifc.start = 1'b0; ifc.row_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.row_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_refill rv=%b rdy=%b required 0 1", ifc.row_valid, ifc.in_ready);
    end
    tick();
    for (int i = 0; i < 4; i++) send_beat(8'h41 + 8'(i), (i == 3), st);
    @(negedge clk);
    checks++;
    if (ifc.row_valid !== 1'b1 || ifc.row_base !== 4'(base2) || ifc.row_len !== 5'd4 ||
        ifc.count !== 5'(m_count)) begin
      errors++;
      $display("FAIL b2b_row rv=%b base=%0d len=%0d cnt=%0d required 1 %0d 4 %0d",
               ifc.row_valid, ifc.row_base, ifc.row_len, ifc.count, base2, m_count);
    end
    tick();
    ack_row();
  endtask

  task automatic test_wrap_full();
    int  st;
    wr_t e;
    start_row();
    send_beat(8'h21, 1'b0, st);
    send_beat(8'h22, 1'b0, st);
    @(negedge clk);
    checks++;
    if (ifc.count !== 5'd12 || ifc.full !== 1'b1 || ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_full cnt=%0d full=%b rdy=%b required 12 1 0", ifc.count, ifc.full, ifc.in_ready);
    end
    tick();
    e.addr = m_ptr[AW-1:0];
    e.data = 8'h23;
    exp_q.push_back(e);
    ifc.in_valid = 1'b1; ifc.in_data = 8'h23; ifc.in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.in_ready !== 1'b0 || ifc.wr_en !== 1'b0) begin
        errors++;
        $display("FAIL full_stall cyc=%0d rdy=%b wr=%b required 0 0", i, ifc.in_ready, ifc.wr_en);
      end
    end
    tick();
    release_pulse(3);
    @(negedge clk);
    checks++;
    if (ifc.count !== 5'd9 || ifc.in_ready !== 1'b1 || ifc.full !== 1'b0) begin
      errors++;
      $display("FAIL full_release cnt=%0d rdy=%b full=%b required 9 1 0", ifc.count, ifc.in_ready, ifc.full);
    end
    tick();
    m_ptr = (m_ptr == DEPTH - 1) ? 0 : m_ptr + 1;
    m_count++;
    ifc.in_valid = 1'b0;
    send_beat(8'h24, 1'b1, st);
    @(negedge clk);
    checks++;
    if (ifc.row_valid !== 1'b1 || ifc.row_base !== 4'd10 || ifc.row_len !== 5'd4 || ifc.count !== 5'd11) begin
      errors++;
      $display("FAIL wrap_row rv=%b base=%0d len=%0d cnt=%0d required 1 10 4 11",
               ifc.row_valid, ifc.row_base, ifc.row_len, ifc.count);
    end
    tick();
    ack_row();
  endtask

  task automatic test_same_cycle();
    int st, base;
    release_pulse(5);
    base = m_ptr;
    start_row();
    ifc.release_en = 1'b1; ifc.release_cnt = 5'd2;
    send_beat(8'h31, 1'b1, st);
    ifc.release_en = 1'b0;
    m_count = m_count - 2;
    @(negedge clk);
    checks++;
    if (ifc.count !== 5'd5 || ifc.row_len !== 5'd1 || ifc.row_base !== 4'(base)) begin
      errors++;
      $display("FAIL same_cycle cnt=%0d len=%0d base=%0d required 5 1 %0d",
               ifc.count, ifc.row_len, ifc.row_base, base);
    end
    tick();
    ack_row();
  endtask

  task automatic test_underflow();
    release_pulse(3);
    @(negedge clk);
    checks++;
    if (ifc.count !== 5'd2 || ifc.err !== 1'b0) begin
      errors++;
      $display("FAIL pre_underflow cnt=%0d err=%b required 2 0", ifc.count, ifc.err);
    end
    tick();
    release_pulse(4);
    @(negedge clk);
    checks++;
    if (ifc.count !== 5'd0 || ifc.empty !== 1'b1 || ifc.err !== 1'b1) begin
      errors++;
      $display("FAIL underflow cnt=%0d empty=%b err=%b required 0 1 1", ifc.count, ifc.empty, ifc.err);
    end
    repeat (5) tick();
    @(negedge clk);
    checks++;
    if (ifc.err !== m_err) begin
      errors++;
      $display("FAIL err_sticky got %b required %b", ifc.err, m_err);
    end
    tick();
  endtask

  task automatic test_overrun();
    int st;
    do_reset();
    @(negedge clk);
    checks++;
    if (ifc.err !== 1'b0) begin errors++; $display("FAIL err_rst_clear got %b required 0", ifc.err); end
    tick();
    start_row();
    for (int i = 0; i < DEPTH; i++) send_beat(8'h80 + 8'(i), 1'b0, st);
    @(negedge clk);
    checks++;
    if (ifc.row_valid !== 1'b1 || ifc.row_len !== 5'd12 || ifc.row_base !== 4'd0 ||
        ifc.err !== 1'b1 || ifc.count !== 5'd12 || ifc.full !== 1'b1 || ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL overrun rv=%b len=%0d base=%0d err=%b cnt=%0d full=%b rdy=%b required 1 12 0 1 12 1 0",
               ifc.row_valid, ifc.row_len, ifc.row_base, ifc.err, ifc.count, ifc.full, ifc.in_ready);
    end
    tick();
    ack_row();
  endtask

  task automatic test_rst_mid_row();
    int st;
    do_reset();
    start_row();
    for (int i = 0; i < 3; i++) send_beat(8'h50 + 8'(i), 1'b0, st);
    ifc.in_valid = 1'b1; ifc.in_data = 8'h55;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.wr_en !== 1'b0) begin errors++; $display("FAIL rst_blocks_write wr=%b required 0", ifc.wr_en); end
    tick();
    rst = 1'b0; ifc.in_valid = 1'b0;
    m_ptr = 0; m_count = 0; m_err = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.count !== 5'd0 || ifc.row_valid !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_row cnt=%0d rv=%b rdy=%b empty=%b required 0 0 0 1",
               ifc.count, ifc.row_valid, ifc.in_ready, ifc.empty);
    end
    tick();
    start_row();
    send_beat(8'h66, 1'b1, st);
    @(negedge clk);
    checks++;
    if (ifc.row_base !== 4'd0 || ifc.row_len !== 5'd1 || ifc.count !== 5'd1) begin
      errors++;
      $display("FAIL rst_ptr_restart base=%0d len=%0d cnt=%0d required 0 1 1", ifc.row_base, ifc.row_len, ifc.count);
    end
    tick();
    ack_row();
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_back_to_back();
    test_wrap_full();
    test_same_cycle();
    test_underflow();
    test_overrun();
    test_rst_mid_row();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifmap_spad_writer.md
Name: ifmap_spad_writer

Overview:
Write-side controller for the PE ifmap scratchpad, the producer end of the read-side stride/data-read counters. It accepts ifmap rows from the global-buffer link over a valid/ready stream and writes them into a circular scratchpad. It tracks occupancy against space freed by the PE read side, and publishes the base address and length of each completed row to the read-side counters.

Parameters:
IFMAP_DATA_WIDTH, 8, width of one ifmap element
SPAD_DEPTH, 12, scratchpad entries; need not be a power of two
ADDR_W, $clog2(SPAD_DEPTH), scratchpad address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: arm capture of the next row (honoured only in IDLE)
in_valid  in  1  stream beat valid
in_data  in  IFMAP_DATA_WIDTH  stream element
in_last  in  1  marks final element of a row
in_ready  out  1  beat accepted when in_valid && in_ready
wr_en  out  1  scratchpad write strobe
wr_addr  out  ADDR_W  scratchpad write address
wr_data  out  IFMAP_DATA_WIDTH  scratchpad write data
release_en  in  1  read side frees entries this cycle
release_cnt  in  ADDR_W+1  number of entries freed, oldest first
row_valid  out  1  completed row available
row_base  out  ADDR_W  address of the row's first element
row_len  out  ADDR_W+1  element count of the row
row_ack  in  1  read side has latched row_base/row_len
count  out  ADDR_W+1  occupied entries
full  out  1  count == SPAD_DEPTH
empty  out  1  count == 0
err  out  1  sticky error flag

Behaviour:
- Reset, sync on rst: state=IDLE, wr_ptr=0, count=0, row_base=0, row_len=0, err=0; in_ready=0, wr_en=0, row_valid=0. rst wins over every other input. rst mid-row discards the partial row.
- States: IDLE, FILL, HOLD.
- IDLE: in_ready=0. On start: row_base<=wr_ptr, beat_cnt<=0, go FILL.
- FILL: in_ready = !full.
  - Accept: wr_en=1 combinationally in the same cycle, wr_addr=wr_ptr, wr_data=in_data. Zero-latency write.
  - wr_ptr increments and wraps SPAD_DEPTH-1 -> 0. beat_cnt increments.
  - Accept with in_last: row_len<=beat_cnt+1, go HOLD.
  - beat_cnt reaching SPAD_DEPTH without in_last: set err, force row_len=SPAD_DEPTH, go HOLD.
- HOLD: row_valid=1, in_ready=0. On row_ack: go IDLE.
  - start coincident with row_ack: go directly to FILL, with row_base<=wr_ptr.
- row_base and row_len are registered and stable while row_valid=1.
- Occupancy, next cycle: count <= count + accept - (release_en ? release_cnt : 0).
  - Simultaneous accept and release are both applied in the same cycle.
  - Release exceeding count+accept: count saturates at 0, err set.
- full and empty are combinational from count. in_ready drops in the same cycle count reaches SPAD_DEPTH.
- Release is legal in every state, including IDLE and HOLD.
- err clears only on rst.
- Arithmetic: count and row_len are ADDR_W+1 wide so SPAD_DEPTH is representable. Pointer wrap uses a compare against SPAD_DEPTH-1, never modulo-by-overflow.

Decomposition:
- Shared package: state enum (IDLE/FILL/HOLD) and a helper constant for SPAD_DEPTH-1.
- One sub-module is natural: spad_wrap_ptr, a wrap-at-DEPTH pointer with en/rst used for wr_ptr. The read side can reuse it later.
- Occupancy update and FSM stay in the top module.

Test Plan:
1. Reset then start, 5 beats (data 1..5, last on 5) with valid held high -> wr_addr 0..4 on consecutive cycles, row_valid=1, row_base=0, row_len=5, count=5; row_ack -> IDLE.
2. Pre-fill count=10 (wr_ptr=10), start, 4-beat row -> wr_addr 10,11,0,1; row_base=10, row_len=4, count=12, full=1 after the 2nd beat only if no release.
3. count=12 (full), in_valid high -> in_ready=0, no wr_en. Then release_en with release_cnt=3 -> count=9 next cycle, in_ready=1, beats resume.
4. count=6, accept a beat and release_cnt=2 in the same cycle -> count=5.
5. count=2, release_cnt=4 -> count=0, empty=1, err=1 (sticky) until rst.
6. 12 beats with no in_last -> err=1, row_len=12, HOLD. Separately, rst asserted mid-row -> count=0, wr_ptr=0, IDLE, row_valid=0 the next cycle.
